pipeline_fetch_lines: RTL
=========================

PIPELINE_FETCH_LINES -- requirements
Module: pipeline_fetch_lines

Interface
REQ-001 The block SHALL have parameter ADDR_WIDTH, default 64: byte-address width.
REQ-002 The block SHALL have parameter INSTR_WIDTH, default 32: instruction width in bits.
REQ-003 The block SHALL have parameter LINE_BYTES, default 64: bytes per buffer line, a power of two and at least 4; S_R_DATA width is LINE_BYTES*8.
REQ-004 The block SHALL have parameter NUM_LINES, default 4: number of resident lines, a power of two and at least 2.
REQ-005 Port clk, input, 1 bit: the single clock.
REQ-006 Port reset, input, 1 bit: reset, synchronous and active-low.
REQ-007 Port pc, input, ADDR_WIDTH bits: fetch address.
REQ-008 Port stall, input, 1 bit: downstream stall; pc does not advance.
REQ-009 Port flush, input, 1 bit: invalidate all lines and abandon any outstanding fill.
REQ-010 Port instruction, output, INSTR_WIDTH bits: fetched word, 0 when instr_valid=0.
REQ-011 Port instr_valid, output, 1 bit: instruction and next_stage_pc are valid.
REQ-012 Port next_stage_pc, output, ADDR_WIDTH bits: pc of the valid instruction, else 0.
REQ-013 Port next_if_pc, output, ADDR_WIDTH bits: next fetch address.
REQ-014 Port misaligned, output, 1 bit: high when pc[1:0] != 0.
REQ-015 Port S_R_ADDR, output, ADDR_WIDTH bits: line-aligned read address, registered.
REQ-016 Port S_R_ADDR_VALID, output, 1 bit: read request strobe, registered.
REQ-017 Port S_R_DATA, input, LINE_BYTES*8 bits: returned line, byte 0 in bits [7:0].
REQ-018 Port S_R_DATA_VALID, input, 1 bit: S_R_DATA is valid this cycle.

Function
REQ-019 A hit SHALL occur when a valid line tag equals pc with the offset bits cleared (pc & ~(LINE_BYTES-1)), pc[1:0]==0, and pc+4 does not cross the line end.
REQ-020 On a hit, in the same cycle and combinationally: instr_valid=1; instruction = S_R_DATA-format bits [(off*8) +: INSTR_WIDTH], where off = pc - tag; next_stage_pc=pc; next_if_pc = stall ? pc : pc+4.
REQ-021 On a miss, misaligned pc, or flush: instr_valid=0, instruction=0, next_stage_pc=0, next_if_pc=pc.
REQ-022 The fill FSM SHALL have three states: IDLE, REQ and WAIT.
- IDLE -> REQ: on a miss with misaligned=0 and flush=0.
- REQ: one cycle with S_R_ADDR = line address and S_R_ADDR_VALID=1, then -> WAIT.
- WAIT: holds until S_R_DATA_VALID=1, then writes the victim line, sets it valid, and -> IDLE.
- In IDLE and WAIT, S_R_ADDR=0 and S_R_ADDR_VALID=0.
REQ-023 The victim SHALL be the first invalid line (lowest index); if every line is valid, it is the round-robin pointer, which advances by 1 modulo NUM_LINES on each fill of a valid line.
REQ-024 A hit SHALL remain servable while a fill is in WAIT.
REQ-025 Data returned in the same cycle as a hit on another line SHALL be written with no effect on that hit.
REQ-026 Flush SHALL clear all valid bits at the next edge. If flush occurs in REQ or WAIT, the FSM SHALL go to a DRAIN state, discard the next S_R_DATA_VALID beat, and then go to IDLE. DRAIN is the fourth state.
REQ-027 S_R_DATA_VALID outside WAIT/DRAIN SHALL be ignored.
REQ-028 Tag compare SHALL use the full ADDR_WIDTH bits; a line at the top of the address space SHALL NOT wrap.

Reset
REQ-029 While reset=0 at a clk edge: all valid bits 0, round-robin pointer 0, FSM to IDLE, S_R_ADDR=0, S_R_ADDR_VALID=0; an outstanding fill is dropped with no drain.
REQ-030 During reset, the combinational outputs SHALL follow REQ-021 because all lines are invalid.

Configuration
REQ-031 When FETCH_PREFETCH_EN is defined: after a demand fill completes, if line+LINE_BYTES is not resident and does not wrap past 2^ADDR_WIDTH, the FSM SHALL go directly to REQ for that address; a demand miss arriving at that point takes priority.
REQ-032 When FETCH_PREFETCH_EN is undefined, only demand fills SHALL occur.

Structure
REQ-033 A shared package fetch_pkg SHALL hold the FSM state enum (IDLE, REQ, WAIT, DRAIN) and a line_addr function.
REQ-034 The line storage (tags, valid bits, data, hit lookup) SHALL be the sub-module fetch_line_store; the FSM and victim selection SHALL stay in pipeline_fetch_lines.

Verification
REQ-035 Cold miss: reset, then pc=0x1008 -> REQ with S_R_ADDR=0x1000; data returned 3 cycles later -> next cycle instr_valid=1, instruction = bytes 8..11, next_if_pc=0x100C.
REQ-036 Capacity: fill 0x0, 0x40, 0x80, 0xC0, 0x100 -> the 0x100 fill evicts line 0; pc=0x0 then misses.
REQ-037 Flush in WAIT: flush asserted, then data returned -> data discarded, FSM in IDLE, pc=0x1000 re-requests.
REQ-038 Misaligned: pc=0x1002 -> misaligned=1, instr_valid=0, no request.
REQ-039 Stall on hit: stall=1 -> next_if_pc=pc, instr_valid=1.
REQ-040 With FETCH_PREFETCH_EN: a 0x2000 fill -> S_R_ADDR=0x2040 is issued; pc=0x2040 then hits with no further request.

Source files
------------

// File: rtl/fetch_pkg.sv
// fetch_pkg: shared definitions for the line-buffered instruction fetch unit.
//   fetch_state_e : fill FSM states (IDLE, REQ, WAIT, DRAIN)
//   line_addr()   : clears the in-line offset bits of a byte address
// Optional feature macro used by the importing files: FETCH_PREFETCH_EN.
package fetch_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    REQ   = 2'd1,
    WAIT  = 2'd2,
    DRAIN = 2'd3
  } fetch_state_e;

  // Width used by line_addr(); callers zero-extend into it and slice back down.
  localparam int LA_W = 128;

  function automatic logic [LA_W-1:0] line_addr(input logic [LA_W-1:0] addr,
                                                input int unsigned     line_bytes);
    logic [LA_W-1:0] mask;
    mask = LA_W'(line_bytes) - LA_W'(1);
    return addr & ~mask;
  endfunction

endpackage

// File: rtl/fetch_line_store.sv
// fetch_line_store: resident line storage for pipeline_fetch_lines.
// Holds NUM_LINES tags/valid bits/line data and performs the hit lookup.
// Ports:
//   clk, reset            clock, synchronous active-low reset
//   flush_i               clears every valid bit at the next edge
//   wr_en_i/wr_idx_i      write a line (tag + data) and mark it valid
//   wr_tag_i/wr_data_i    line address and line contents to write
//   pc_i                  lookup address
//   hit_o/instr_o         lookup result and selected instruction word
//   pc_line_o             pc_i with the offset bits cleared
//   valid_o               per-line valid bits (for victim selection)
//   probe_addr_i/probe_hit_o  residency probe, only with FETCH_PREFETCH_EN
module fetch_line_store
  import fetch_pkg::*;
#(
  parameter int ADDR_WIDTH  = 64,
  parameter int INSTR_WIDTH = 32,
  parameter int LINE_BYTES  = 64,
  parameter int NUM_LINES   = 4,
  localparam int IDX_W      = $clog2(NUM_LINES),
  localparam int LINE_BITS  = LINE_BYTES * 8
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   flush_i,
  input  logic                   wr_en_i,
  input  logic [IDX_W-1:0]       wr_idx_i,
  input  logic [ADDR_WIDTH-1:0]  wr_tag_i,
  input  logic [LINE_BITS-1:0]   wr_data_i,
  input  logic [ADDR_WIDTH-1:0]  pc_i,
  output logic                   hit_o,
  output logic [INSTR_WIDTH-1:0] instr_o,
  output logic [ADDR_WIDTH-1:0]  pc_line_o,
  output logic [NUM_LINES-1:0]   valid_o
`ifdef FETCH_PREFETCH_EN
  ,
  input  logic [ADDR_WIDTH-1:0]  probe_addr_i,
  output logic                   probe_hit_o
`endif
);

  localparam int OFF_W = $clog2(LINE_BYTES);

  logic [ADDR_WIDTH-1:0] tag_q  [NUM_LINES];
  logic [LINE_BITS-1:0]  data_q [NUM_LINES];
  logic [NUM_LINES-1:0]  valid_q;

  logic [LA_W-1:0]       line_full;
  logic                  unused_line_hi;
  logic [ADDR_WIDTH-1:0] pc_line;
  logic [OFF_W-1:0]      off;
  logic                  match;
  logic [LINE_BITS-1:0]  sel_data;

  assign line_full      = line_addr(LA_W'(pc_i), LINE_BYTES);
  assign pc_line        = line_full[ADDR_WIDTH-1:0];
  assign unused_line_hi = ^line_full[LA_W-1:ADDR_WIDTH];
  assign off            = pc_i[OFF_W-1:0];

  // Full-width tag compare: a line at the top of the address space never
  // aliases a line at address 0.
  always_comb begin
    match    = 1'b0;
    sel_data = '0;
    for (int i = 0; i < NUM_LINES; i++) begin
      if (valid_q[i] && (tag_q[i] == pc_line)) begin
        match    = 1'b1;
        sel_data = data_q[i];
      end
    end
  end

  // pc+4 stays inside the line as long as the offset is at most LINE_BYTES-4.
  assign hit_o     = match && (pc_i[1:0] == 2'b00) && (off <= OFF_W'(LINE_BYTES - 4));
  assign instr_o   = hit_o ? sel_data[{off, 3'b000} +: INSTR_WIDTH] : '0;
  assign pc_line_o = pc_line;
  assign valid_o   = valid_q;

  always_ff @(posedge clk) begin
    if (!reset) begin
      valid_q <= '0;
    end else if (flush_i) begin
      valid_q <= '0;
    end else if (wr_en_i) begin
      valid_q[wr_idx_i] <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en_i && !flush_i) begin
      tag_q[wr_idx_i]  <= wr_tag_i;
      data_q[wr_idx_i] <= wr_data_i;
    end
  end

`ifdef FETCH_PREFETCH_EN
  always_comb begin
    probe_hit_o = 1'b0;
    for (int i = 0; i < NUM_LINES; i++) begin
      if (valid_q[i] && (tag_q[i] == probe_addr_i)) probe_hit_o = 1'b1;
    end
  end
`endif

endmodule

// File: rtl/pipeline_fetch_lines.sv
// pipeline_fetch_lines: instruction fetch stage backed by NUM_LINES resident
// lines, refilled over a simple one-beat read port.
// Ports:
//   clk, reset                  clock, synchronous active-low reset
//   pc, stall, flush            fetch address, downstream stall, invalidate-all
//   instruction, instr_valid    fetched word (0 unless a hit)
//   next_stage_pc, next_if_pc   pc of the valid word, next fetch address
//   misaligned                  pc[1:0] != 0
//   S_R_ADDR, S_R_ADDR_VALID    registered line read request
//   S_R_DATA, S_R_DATA_VALID    returned line, byte 0 in bits [7:0]
// Optional: `define FETCH_PREFETCH_EN to prefetch the next sequential line
// after every demand fill.
//
// state | meaning
// IDLE  | no fill outstanding; a demand miss starts one
// REQ   | S_R_ADDR/S_R_ADDR_VALID presented for one cycle
// WAIT  | waiting for the returned line; hits are still served
// DRAIN | flushed while a fill was outstanding; swallow its beat
module pipeline_fetch_lines
  import fetch_pkg::*;
#(
  parameter int ADDR_WIDTH  = 64,
  parameter int INSTR_WIDTH = 32,
  parameter int LINE_BYTES  = 64,
  parameter int NUM_LINES   = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [ADDR_WIDTH-1:0]   pc,
  input  logic                    stall,
  input  logic                    flush,
  output logic [INSTR_WIDTH-1:0]  instruction,
  output logic                    instr_valid,
  output logic [ADDR_WIDTH-1:0]   next_stage_pc,
  output logic [ADDR_WIDTH-1:0]   next_if_pc,
  output logic                    misaligned,
  output logic [ADDR_WIDTH-1:0]   S_R_ADDR,
  output logic                    S_R_ADDR_VALID,
  input  logic [LINE_BYTES*8-1:0] S_R_DATA,
  input  logic                    S_R_DATA_VALID
);

  localparam int IDX_W = $clog2(NUM_LINES);

  fetch_state_e          state_q, state_d;
  logic [ADDR_WIDTH-1:0] fill_addr_q, fill_addr_d;
  logic [ADDR_WIDTH-1:0] s_r_addr_q;
  logic                  s_r_addr_valid_q;
  logic [IDX_W-1:0]      rr_q;
  logic [IDX_W-1:0]      victim;
  logic                  victim_found;

  logic                   store_hit;
  logic [INSTR_WIDTH-1:0] store_instr;
  logic [ADDR_WIDTH-1:0]  pc_line;
  logic [NUM_LINES-1:0]   line_valid;
  logic                   all_valid;
  logic                   hit_ok;
  logic                   demand_miss;
  logic                   fill_done;

`ifdef FETCH_PREFETCH_EN
  logic                  demand_q, demand_d;
  logic [ADDR_WIDTH-1:0] pf_addr;
  logic                  pf_wrap;
  logic                  pf_resident;

  assign pf_addr = fill_addr_q + ADDR_WIDTH'(LINE_BYTES);
  assign pf_wrap = (pf_addr == '0);
`endif

  fetch_line_store #(
    .ADDR_WIDTH  (ADDR_WIDTH),
    .INSTR_WIDTH (INSTR_WIDTH),
    .LINE_BYTES  (LINE_BYTES),
    .NUM_LINES   (NUM_LINES)
  ) u_store (
    .clk       (clk),
    .reset     (reset),
    .flush_i   (flush),
    .wr_en_i   (fill_done),
    .wr_idx_i  (victim),
    .wr_tag_i  (fill_addr_q),
    .wr_data_i (S_R_DATA),
    .pc_i      (pc),
    .hit_o     (store_hit),
    .instr_o   (store_instr),
    .pc_line_o (pc_line),
    .valid_o   (line_valid)
`ifdef FETCH_PREFETCH_EN
    ,
    .probe_addr_i (pf_addr),
    .probe_hit_o  (pf_resident)
`endif
  );

  assign misaligned  = (pc[1:0] != 2'b00);
  assign hit_ok      = store_hit && !flush;
  assign demand_miss = !store_hit && !misaligned && !flush;
  // A beat coinciding with flush is dropped so no line becomes valid after it.
  assign fill_done   = (state_q == WAIT) && S_R_DATA_VALID && !flush;
  assign all_valid   = &line_valid;

  assign instr_valid   = hit_ok;
  assign instruction   = hit_ok ? store_instr : '0;
  assign next_stage_pc = hit_ok ? pc : '0;
  assign next_if_pc    = (hit_ok && !stall) ? pc + ADDR_WIDTH'(4) : pc;

  assign S_R_ADDR       = s_r_addr_q;
  assign S_R_ADDR_VALID = s_r_addr_valid_q;

  // Lowest-index invalid line first; round-robin only once all are valid.
  always_comb begin
    victim       = rr_q;
    victim_found = 1'b0;
    for (int i = 0; i < NUM_LINES; i++) begin
      if (!victim_found && !line_valid[i]) begin
        victim       = IDX_W'(i);
        victim_found = 1'b1;
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    fill_addr_d = fill_addr_q;
`ifdef FETCH_PREFETCH_EN
    demand_d    = demand_q;
`endif
    case (state_q)
      IDLE: begin
        if (demand_miss) begin
          state_d     = REQ;
          fill_addr_d = pc_line;
`ifdef FETCH_PREFETCH_EN
          demand_d    = 1'b1;
`endif
        end
      end
      REQ:  state_d = flush ? DRAIN : WAIT;
      WAIT: begin
        if (flush) begin
          // The outstanding beat either arrives now (dropped) or later (drained).
          state_d = S_R_DATA_VALID ? IDLE : DRAIN;
        end else if (S_R_DATA_VALID) begin
          state_d = IDLE;
`ifdef FETCH_PREFETCH_EN
          if (demand_q) begin
            // A miss on a different line beats the prefetch; the line being
            // written right now will hit next cycle, so it is not a miss.
            if (demand_miss && (pc_line != fill_addr_q)) begin
              state_d     = REQ;
              fill_addr_d = pc_line;
              demand_d    = 1'b1;
            end else if (!pf_wrap && !pf_resident) begin
              state_d     = REQ;
              fill_addr_d = pf_addr;
              demand_d    = 1'b0;
            end
          end
`endif
        end
      end
      DRAIN: if (S_R_DATA_VALID) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q          <= IDLE;
      fill_addr_q      <= '0;
      s_r_addr_q       <= '0;
      s_r_addr_valid_q <= 1'b0;
      rr_q             <= '0;
`ifdef FETCH_PREFETCH_EN
      demand_q         <= 1'b0;
`endif
    end else begin
      state_q          <= state_d;
      fill_addr_q      <= fill_addr_d;
      s_r_addr_q       <= (state_d == REQ) ? fill_addr_d : '0;
      s_r_addr_valid_q <= (state_d == REQ);
      if (fill_done && all_valid) rr_q <= rr_q + IDX_W'(1);
`ifdef FETCH_PREFETCH_EN
      demand_q         <= demand_d;
`endif
    end
  end

endmodule
